board_state_writer: RTL and testbench

Owns the Minesweeper board state: the 8x8 cursor and the `flagMap` and `stepMap` vectors that the gameboard renderer reads. It turns player button presses into map updates and win/loss status. After every change it issues redraw requests for the affected cells over a valid/ack handshake to the renderer. It sits between the synchronized KEY inputs and the gameboard drawing path.

---
 rtl/board_state_writer.sv | 162 ++++++++++++++++
 tb/tb_board_state_writer.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/board_state_writer.sv
// board_state_writer
//   Owns the Minesweeper board state (8x8 cursor, flagMap, stepMap) and the
//   win/loss flags. Button rising edges in IDLE update the state in one cycle;
//   each change is followed by one (flag/step) or two (move: old cell, then new
//   cell) redraw requests over a valid/ack handshake.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   mineMap[63:0]       : mine placement, bit y*8+x
//   btn_*               : synchronized button levels (up/down/left/right/flag/step)
//   flagMap, stepMap    : per-cell flagged / uncovered bits
//   cursor_x, cursor_y  : cursor position
//   redraw_req/_cell/_ack : redraw handshake, cell = {y,x}
//   game_over, game_won : sticky end-of-game status
module board_state_writer (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] mineMap,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        btn_flag,
    input  logic        btn_step,
    output logic [63:0] flagMap,
    output logic [63:0] stepMap,
    output logic [2:0]  cursor_x,
    output logic [2:0]  cursor_y,
    output logic        redraw_req,
    output logic [5:0]  redraw_cell,
    input  logic        redraw_ack,
    output logic        game_over,
    output logic        game_won
);

    typedef enum logic [1:0] {ST_IDLE, ST_REQ_A, ST_REQ_B, ST_LOCKED} state_t;

    state_t      r_state, w_state_n;
    logic [5:0]  r_btn_q;
    logic [63:0] r_flag, r_step, w_flag_n, w_step_n;
    logic [2:0]  r_cx, r_cy, w_cx_n, w_cy_n;
    logic        r_req, w_req_n;
    logic [5:0]  r_cell, w_cell_n;
    logic [5:0]  r_pend_cell, w_pend_cell_n;   // new cell of a pending move
    logic        r_pend, w_pend_n;
    logic        r_over, r_won, w_over_n, w_won_n;

    logic [5:0]  w_btn, w_press, w_cur;

    // bit order doubles as priority order: step is the MSB
    assign w_btn   = {btn_step, btn_flag, btn_up, btn_down, btn_left, btn_right};
    assign w_press = w_btn & ~r_btn_q;
    assign w_cur   = {r_cy, r_cx};

    always_comb begin
        w_state_n     = r_state;
        w_flag_n      = r_flag;
        w_step_n      = r_step;
        w_cx_n        = r_cx;
        w_cy_n        = r_cy;
        w_req_n       = r_req;
        w_cell_n      = r_cell;
        w_pend_cell_n = r_pend_cell;
        w_pend_n      = r_pend;
        w_over_n      = r_over;
        w_won_n       = r_won;
        case (r_state)
            ST_IDLE: begin
                if (w_press[5]) begin
                    // an ignored step still swallows lower-priority presses
                    if (!r_flag[w_cur] && !r_step[w_cur]) begin
                        w_step_n  = r_step | (64'd1 << w_cur);
                        w_req_n   = 1'b1;
                        w_cell_n  = w_cur;
                        w_pend_n  = 1'b0;
                        w_state_n = ST_REQ_A;
                        if (mineMap[w_cur])
                            w_over_n = 1'b1;
                        else if ((w_step_n | mineMap) == 64'hFFFF_FFFF_FFFF_FFFF)
                            w_won_n = 1'b1;
                    end
                end else if (w_press[4]) begin
                    if (!r_step[w_cur]) begin
                        w_flag_n  = r_flag ^ (64'd1 << w_cur);
                        w_req_n   = 1'b1;
                        w_cell_n  = w_cur;
                        w_pend_n  = 1'b0;
                        w_state_n = ST_REQ_A;
                    end
                end else if (|w_press[3:0]) begin
                    if (w_press[3])      w_cy_n = r_cy - 3'd1;
                    else if (w_press[2]) w_cy_n = r_cy + 3'd1;
                    else if (w_press[1]) w_cx_n = r_cx - 3'd1;
                    else                 w_cx_n = r_cx + 3'd1;
                    w_req_n       = 1'b1;
                    w_cell_n      = w_cur;
                    w_pend_cell_n = {w_cy_n, w_cx_n};
                    w_pend_n      = 1'b1;
                    w_state_n     = ST_REQ_A;
                end
            end
            ST_REQ_A: begin
                if (redraw_ack) begin
                    if (r_pend) begin
                        w_cell_n  = r_pend_cell;
                        w_pend_n  = 1'b0;
                        w_state_n = ST_REQ_B;
                    end else begin
                        w_req_n   = 1'b0;
                        w_state_n = (r_over || r_won) ? ST_LOCKED : ST_IDLE;
                    end
                end
            end
            ST_REQ_B: begin
                if (redraw_ack) begin
                    w_req_n   = 1'b0;
                    w_state_n = ST_IDLE;
                end
            end
            default: ;  // ST_LOCKED: hold until reset
        endcase
    end

    always_ff @(posedge clk) begin
        // btn_q follows the buttons even in reset so a held button never fires
        r_btn_q <= w_btn;
        if (reset) begin
            r_state     <= ST_IDLE;
            r_flag      <= '0;
            r_step      <= '0;
            r_cx        <= '0;
            r_cy        <= '0;
            r_req       <= 1'b0;
            r_cell      <= '0;
            r_pend_cell <= '0;
            r_pend      <= 1'b0;
            r_over      <= 1'b0;
            r_won       <= 1'b0;
        end else begin
            r_state     <= w_state_n;
            r_flag      <= w_flag_n;
            r_step      <= w_step_n;
            r_cx        <= w_cx_n;
            r_cy        <= w_cy_n;
            r_req       <= w_req_n;
            r_cell      <= w_cell_n;
            r_pend_cell <= w_pend_cell_n;
            r_pend      <= w_pend_n;
            r_over      <= w_over_n;
            r_won       <= w_won_n;
        end
    end

    assign flagMap     = r_flag;
    assign stepMap     = r_step;
    assign cursor_x    = r_cx;
    assign cursor_y    = r_cy;
    assign redraw_req  = r_req;
    assign redraw_cell = r_cell;
    assign game_over   = r_over;
    assign game_won    = r_won;

endmodule

// File: tb/tb_board_state_writer.sv
module tb_board_state_writer;

    localparam logic [5:0] B_STEP  = 6'b100000;
    localparam logic [5:0] B_FLAG  = 6'b010000;
    localparam logic [5:0] B_UP    = 6'b001000;
    localparam logic [5:0] B_DOWN  = 6'b000100;
    localparam logic [5:0] B_LEFT  = 6'b000010;
    localparam logic [5:0] B_RIGHT = 6'b000001;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [63:0] mineMap = '0;
    logic [5:0]  btns = '0;
    logic        redraw_ack = 1'b0;
    logic [63:0] flagMap, stepMap;
    logic [2:0]  cursor_x, cursor_y;
    logic        redraw_req, game_over, game_won;
    logic [5:0]  redraw_cell;

    board_state_writer dut (
        .clk(clk), .reset(reset), .mineMap(mineMap),
        .btn_up(btns[3]), .btn_down(btns[2]), .btn_left(btns[1]), .btn_right(btns[0]),
        .btn_flag(btns[4]), .btn_step(btns[5]),
        .flagMap(flagMap), .stepMap(stepMap), .cursor_x(cursor_x), .cursor_y(cursor_y),
        .redraw_req(redraw_req), .redraw_cell(redraw_cell), .redraw_ack(redraw_ack),
        .game_over(game_over), .game_won(game_won)
    );

    always #5 clk = ~clk;

    int nchecks = 0;
    int nerr = 0;

    // reference model
    logic [63:0] mflag, mstep, mmine;
    int          mx, my;
    bit          mover, mwon, mlocked;
    int          exp_q[$];
    bit          ack_hold = 1'b0;
    bit          ack_force = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_state(input string tag);
        chk({tag, " flagMap"}, flagMap, mflag);
        chk({tag, " stepMap"}, stepMap, mstep);
        chk({tag, " cursor_x"}, 64'(cursor_x), 64'(mx));
        chk({tag, " cursor_y"}, 64'(cursor_y), 64'(my));
        chk({tag, " game_over"}, 64'(game_over), 64'(mover));
        chk({tag, " game_won"}, 64'(game_won), 64'(mwon));
    endtask

    // ack driver: random unless held low or forced high
    initial forever begin
        @(negedge clk);
        if (ack_hold)       redraw_ack = 1'b0;
        else if (ack_force) redraw_ack = 1'b1;
        else                redraw_ack = ($urandom_range(0, 2) != 0);
    end

    // monitor: a transfer happens at the next posedge iff req && ack now
    initial forever begin
        @(negedge clk);
        #1;
        if (!reset && redraw_req && redraw_ack) begin
            nchecks++;
            if (exp_q.size() == 0) begin
                nerr++;
                $display("FAIL unexpected_redraw: got cell %0d expected none", redraw_cell);
            end else begin
                int e;
                e = exp_q.pop_front();
                if (32'(redraw_cell) != e) begin
                    nerr++;
                    $display("FAIL redraw_cell: got %0d expected %0d", redraw_cell, e);
                end
            end
        end
    end

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk);
            #1;
            if (!redraw_req && exp_q.size() == 0) done = 1'b1;
        end
        if (!done) begin
            nchecks++;
            nerr++;
            $display("FAIL wait_idle: got req=%0b pending=%0d expected idle", redraw_req, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic do_reset(input logic [5:0] hold, input logic [63:0] mine);
        @(negedge clk);
        reset = 1'b1;
        btns = hold;
        mineMap = mine;
        exp_q.delete();
        mflag = '0; mstep = '0; mmine = mine;
        mx = 0; my = 0; mover = 0; mwon = 0; mlocked = 0;
        @(negedge clk);
        #1;
        chk("reset redraw_req", 64'(redraw_req), 64'd0);
        chk("reset redraw_cell", 64'(redraw_cell), 64'd0);
        check_state("reset");
        @(negedge clk);
        reset = 1'b0;
    endtask

    // apply one press to the model; returns whether a redraw is expected
    function automatic bit model_apply(input logic [5:0] m);
        int  c, remaining;
        bit  act;
        act = 0;
        c = my * 8 + mx;
        if (mlocked) return 0;
        if (m[5]) begin
            if (!mflag[c] && !mstep[c]) begin
                mstep[c] = 1'b1;
                exp_q.push_back(c);
                act = 1;
                if (mmine[c]) mover = 1;
                else begin
                    remaining = 0;
                    for (int i = 0; i < 64; i++)
                        if (!mmine[i] && !mstep[i]) remaining++;
                    if (remaining == 0) mwon = 1;
                end
            end
        end else if (m[4]) begin
            if (!mstep[c]) begin
                mflag[c] = ~mflag[c];
                exp_q.push_back(c);
                act = 1;
            end
        end else if (m[3:0] != 0) begin
            exp_q.push_back(c);
            if (m[3])      my = (my + 7) % 8;
            else if (m[2]) my = (my + 1) % 8;
            else if (m[1]) mx = (mx + 7) % 8;
            else           mx = (mx + 1) % 8;
            exp_q.push_back(my * 8 + mx);
            act = 1;
        end
        if (act && (mover || mwon)) mlocked = 1;
        return act;
    endfunction

    task automatic press(input logic [5:0] m);
        bit act;
        wait_idle();
        @(negedge clk);
        btns = m;
        act = model_apply(m);
        @(negedge clk);
        btns = '0;
        #1;
        chk("press redraw_req", 64'(redraw_req), 64'(act));
        check_state("press");
    endtask

    initial begin
        logic [63:0] rmine;
        logic [5:0]  rm;

        // held button through reset does not fire
        do_reset(B_RIGHT, 64'd0);
        repeat (3) begin
            @(negedge clk);
            #1;
            chk("held cursor_x", 64'(cursor_x), 64'd0);
            chk("held redraw_req", 64'(redraw_req), 64'd0);
        end
        @(negedge clk);
        btns = '0;
        press(B_RIGHT);

        // wrap-around moves
        do_reset(6'd0, 64'd0);
        press(B_LEFT);
        press(B_UP);

        // flag / step on a mine at cell 9
        do_reset(6'd0, 64'h200);
        press(B_RIGHT);
        press(B_DOWN);
        press(B_FLAG);
        chk("flag9 set", 64'(flagMap[9]), 64'd1);
        press(B_STEP);
        press(B_FLAG);
        press(B_STEP);
        chk("mine game_over", 64'(game_over), 64'd1);
        press(B_RIGHT);
        press(B_FLAG);

        // win: uncover cells 1..63
        do_reset(6'd0, 64'h1);
        for (int i = 1; i < 64; i++) begin
            press(B_RIGHT);
            if (i % 8 == 0) press(B_DOWN);
            press(B_STEP);
        end
        chk("win game_won", 64'(game_won), 64'd1);
        chk("win game_over", 64'(game_over), 64'd0);

        // ack withheld: request holds, presses dropped
        do_reset(6'd0, 64'd0);
        ack_hold = 1'b1;
        press(B_STEP);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i == 5) btns = B_FLAG;
            if (i == 6) btns = '0;
            #1;
            if (i % 4 == 0) begin
                chk("hold redraw_req", 64'(redraw_req), 64'd1);
                chk("hold redraw_cell", 64'(redraw_cell), 64'd0);
            end
        end
        ack_force = 1'b1;
        ack_hold = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("release redraw_req", 64'(redraw_req), 64'd0);
        chk("release flagMap", flagMap, 64'd0);
        ack_force = 1'b0;

        // step beats right in the same cycle; reset during REQ_A
        do_reset(6'd0, 64'd0);
        ack_hold = 1'b1;
        press(B_STEP | B_RIGHT);
        @(negedge clk);
        #1;
        chk("reqA redraw_req", 64'(redraw_req), 64'd1);
        do_reset(6'd0, 64'd0);
        ack_hold = 1'b0;
        repeat (3) begin
            @(negedge clk);
            #1;
            chk("post-reset redraw_req", 64'(redraw_req), 64'd0);
        end

        // randomized presses against the model
        do_reset(6'd0, 64'd0);
        for (int n = 0; n < 300; n++) begin
            if (mlocked) begin
                rmine = '0;
                for (int i = 0; i < 64; i++) rmine[i] = ($urandom_range(0, 7) == 0);
                do_reset(6'd0, rmine);
            end
            if ($urandom_range(0, 1) == 1) rm = 6'b1 << $urandom_range(0, 5);
            else                           rm = 6'($urandom);
            press(rm);
        end

        wait_idle();
        chk("scoreboard drained", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", nerr, nchecks);
        $finish;
    end

endmodule
